prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream stage of the 9-bit single-cycle core. Fills instruction memory before the core runs.
- Accepts machine-code words over a valid/ready stream and writes them sequentially into instruction ROM from address 0.
- Holds the core in reset while loading, releases it, then watches the core's done flag to finish the run.
- Faults if the program would reach the reserved all-ones address, which is the core's done PC.

Parameters:
- D, 12, program counter / instruction address width.
- W, 9, machine-code word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle load request.
- in_valid  input  1  stream word valid.
- in_data  input  W  machine-code word.
- in_last  input  1  marks the final word of the program; qualified by in_valid.
- in_ready  output  1  loader accepts a word this cycle.
- rom_we  output  1  instruction memory write enable.
- rom_addr  output  D  instruction memory write address.
- rom_wdat  output  W  instruction memory write data.
- cpu_reset  output  1  active-high reset to the core.
- cpu_done  input  1  core done flag (PC == all ones).
- busy  output  1  high in LOAD, RELEASE and RUN.
- run_done  output  1  one-cycle pulse when a run completes.
- err_ovf  output  1  program-overflow fault, sticky.
- loaded_cnt  output  D  words accepted in the last or current load.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, ptr=0, loaded_cnt=0, rom_we=0, rom_addr=0, rom_wdat=0, cpu_reset=1, run_done=0, err_ovf=0. in_ready=0 and busy=0 follow from state.
- States: IDLE, LOAD, RELEASE, RUN, FAULT.
- in_ready = (state==LOAD). It is a combinational decode of the state register only and does not depend on in_valid.
- busy = state in {LOAD, RELEASE, RUN}.
- cpu_reset is registered: 0 only while state==RUN, 1 in every other state.
- IDLE:
  - start=1 -> LOAD next cycle; ptr<=0, loaded_cnt<=0, err_ovf<=0.
- LOAD:
  - Transfer = in_valid & in_ready.
  - On a transfer, the next cycle has rom_we=1, rom_addr=ptr (pre-increment), rom_wdat=in_data. This is a 1-cycle write latency.
  - Also on a transfer: ptr<=ptr+1, loaded_cnt<=loaded_cnt+1.
  - rom_we=0 in any cycle not following a transfer. rom_addr and rom_wdat hold their last values.
  - Transfer with in_last=1 -> RELEASE.
  - Transfer with in_last=0 at ptr==2^D-2 -> FAULT. That word is still written. The next address would be the reserved done PC.
  - start is ignored in LOAD.
- RELEASE:
  - Single cycle; carries the final rom_we write. cpu_reset stays 1.
  - Unconditionally -> RUN.
- RUN:
  - cpu_reset=0; start and the stream are ignored.
  - cpu_done=1 -> IDLE. run_done=1 for exactly the next cycle, and cpu_reset returns to 1 in that same cycle.
- FAULT:
  - err_ovf=1, cpu_reset=1; no writes.
  - start=1 -> LOAD with the same clearing as in IDLE, err_ovf<=0.
- Boundaries:
  - A 1-word program (in_last on the first transfer) is legal; loaded_cnt=1.
  - Maximum program length is 2^D-1 words. A last word at ptr==2^D-2 is legal and goes to RELEASE.
  - Back-to-back transfers every cycle are sustained; rom_we stays high continuously.
  - in_data and in_last are ignored when in_valid=0.
  - Asynchronous reset mid-LOAD or mid-RUN aborts immediately to reset values. The core is re-held in reset. Memory contents already written are undefined from the core's view.
  - loaded_cnt holds its value through RUN, IDLE and FAULT until the next start.

Test Plan:
- Reset, start, then stream 3 words 0x1A5, 0x0F0, 0x1FF (last) on consecutive cycles -> rom_we high for 3 cycles at addr 0,1,2 with matching data; RELEASE; cpu_reset falls 2 cycles after the last transfer; loaded_cnt=3.
- In RUN, raise cpu_done -> run_done pulses for 1 cycle, cpu_reset=1, busy=0, state IDLE; a start pulse held high during RUN was ignored.
- Stream with in_valid toggling 1,0,1,0 -> writes only after valid cycles; rom_we gaps match; addresses remain contiguous.
- Set D=4 and stream 15 words with no in_last -> 15th word written at addr 14, err_ovf=1, in_ready=0, cpu_reset=1. Start -> err_ovf=0, loading restarts at addr 0.
- Set D=4, 15 words with in_last on the 15th -> no fault, RUN entered, loaded_cnt=15.
- Assert reset low mid-LOAD after 2 words -> all outputs return to reset values asynchronously. Start -> new load writes from addr 0.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: streams machine-code words into instruction ROM from address 0,
// holds the core in reset while loading, then runs it until its done flag.
module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         rom_we,
    output logic [D-1:0] rom_addr,
    output logic [W-1:0] rom_wdat,
    output logic         cpu_reset,
    input  logic         cpu_done,
    output logic         busy,
    output logic         run_done,
    output logic         err_ovf,
    output logic [D-1:0] loaded_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    // Highest legal write address; the all-ones address is the core's done PC.
    localparam logic [D-1:0] PTR_LIMIT = {{(D-1){1'b1}}, 1'b0};

    logic [2:0]   state;
    logic [2:0]   state_next;
    logic [D-1:0] ptr;
    logic         xfer;
    logic         restart;

    assign in_ready = (state == S_LOAD);
    assign busy     = (state == S_LOAD) || (state == S_RELEASE) || (state == S_RUN);
    assign xfer     = in_valid && in_ready;
    assign restart  = start && ((state == S_IDLE) || (state == S_FAULT));

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_LOAD;
            S_LOAD: begin
                if (xfer) begin
                    if (in_last)
                        state_next = S_RELEASE;
                    else if (ptr == PTR_LIMIT)
                        state_next = S_FAULT;
                end
            end
            S_RELEASE: state_next = S_RUN;
            S_RUN:     if (cpu_done) state_next = S_IDLE;
            S_FAULT:   if (start) state_next = S_LOAD;
            default:   state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            loaded_cnt <= '0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdat   <= '0;
            cpu_reset  <= 1'b1;
            run_done   <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            state     <= state_next;
            cpu_reset <= (state_next != S_RUN);
            run_done  <= (state == S_RUN) && cpu_done;
            rom_we    <= xfer;

            if (restart) begin
                ptr        <= '0;
                loaded_cnt <= '0;
                err_ovf    <= 1'b0;
            end

            if (xfer) begin
                rom_addr   <= ptr;
                rom_wdat   <= in_data;
                ptr        <= ptr + 1'b1;
                loaded_cnt <= loaded_cnt + 1'b1;
            end

            if (state_next == S_FAULT && state == S_LOAD)
                err_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default-width instance and a D=4 instance
// share stimulus; each scenario checks the instance it targets.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [8:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       cpu_done = 1'b0;

    logic        a_in_ready, a_rom_we, a_cpu_reset, a_busy, a_run_done, a_err_ovf;
    logic [11:0] a_rom_addr, a_loaded_cnt;
    logic [8:0]  a_rom_wdat;

    logic        b_in_ready, b_rom_we, b_cpu_reset, b_busy, b_run_done, b_err_ovf;
    logic [3:0]  b_rom_addr, b_loaded_cnt;
    logic [8:0]  b_rom_wdat;

    int n_vec = 0;
    int n_err = 0;

    prog_loader u_dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(a_in_ready),
        .rom_we(a_rom_we), .rom_addr(a_rom_addr), .rom_wdat(a_rom_wdat),
        .cpu_reset(a_cpu_reset), .cpu_done(cpu_done), .busy(a_busy),
        .run_done(a_run_done), .err_ovf(a_err_ovf), .loaded_cnt(a_loaded_cnt)
    );

    prog_loader #(.D(4), .W(9)) u_dut4 (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(b_in_ready),
        .rom_we(b_rom_we), .rom_addr(b_rom_addr), .rom_wdat(b_rom_wdat),
        .cpu_reset(b_cpu_reset), .cpu_done(cpu_done), .busy(b_busy),
        .run_done(b_run_done), .err_ovf(b_err_ovf), .loaded_cnt(b_loaded_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; cpu_done = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    logic [8:0] vec3 [3];

    initial begin
        vec3[0] = 9'h1A5; vec3[1] = 9'h0F0; vec3[2] = 9'h1FF;

        // Reset state
        tick();
        check("rst_we",    32'(a_rom_we), 0);
        check("rst_addr",  32'(a_rom_addr), 0);
        check("rst_wdat",  32'(a_rom_wdat), 0);
        check("rst_cpurst",32'(a_cpu_reset), 1);
        check("rst_busy",  32'(a_busy), 0);
        check("rst_ready", 32'(a_in_ready), 0);
        check("rst_done",  32'(a_run_done), 0);
        check("rst_ovf",   32'(a_err_ovf), 0);
        check("rst_cnt",   32'(a_loaded_cnt), 0);
        reset = 1'b1;
        tick();

        // Three-word program on consecutive cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ld_ready", 32'(a_in_ready), 1);
        check("ld_busy",  32'(a_busy), 1);
        check("ld_we0",   32'(a_rom_we), 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vec3[i]; in_last = (i == 2);
            tick();
            check("w3_we",   32'(a_rom_we), 1);
            check("w3_addr", 32'(a_rom_addr), 32'(i));
            check("w3_wdat", 32'(a_rom_wdat), 32'(vec3[i]));
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("rel_ready",  32'(a_in_ready), 0);
        check("rel_cpurst", 32'(a_cpu_reset), 1);
        check("rel_busy",   32'(a_busy), 1);
        start = 1'b1;
        tick();
        check("run_cpurst", 32'(a_cpu_reset), 0);
        check("run_we",     32'(a_rom_we), 0);
        check("run_cnt",    32'(a_loaded_cnt), 3);
        in_valid = 1'b1; in_data = 9'h055;
        tick();
        tick();
        check("run_ign_start", 32'(a_cpu_reset), 0);
        check("run_ign_we",    32'(a_rom_we), 0);
        check("run_ign_ready", 32'(a_in_ready), 0);
        start = 1'b0; in_valid = 1'b0;

        // Core reports done
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("fin_pulse",  32'(a_run_done), 1);
        check("fin_cpurst", 32'(a_cpu_reset), 1);
        check("fin_busy",   32'(a_busy), 0);
        tick();
        check("fin_pulse1", 32'(a_run_done), 0);
        check("fin_idle",   32'(a_busy), 0);
        check("fin_cnt",    32'(a_loaded_cnt), 3);

        // Gapped stream: valid 1,0,1,0,1(last); garbage data/last while invalid
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = (i % 2 == 0) ? 9'(9'h040 + i) : 9'h1EE;
            in_last  = (i == 4) || (i % 2 == 1);
            tick();
            check("gap_we", 32'(a_rom_we), 32'(i % 2 == 0));
            if (i % 2 == 0) begin
                check("gap_addr", 32'(a_rom_addr), 32'(i / 2));
                check("gap_wdat", 32'(a_rom_wdat), 32'(9'h040 + i));
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        check("gap_run", 32'(a_cpu_reset), 0);
        check("gap_cnt", 32'(a_loaded_cnt), 3);

        // D=4: 15 words without in_last overflows
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_data = 9'(i * 7 + 3); in_last = 1'b0;
            tick();
            check("ovf_we",   32'(b_rom_we), 1);
            check("ovf_addr", 32'(b_rom_addr), 32'(i));
            check("ovf_wdat", 32'(b_rom_wdat), 32'(9'(i * 7 + 3)));
        end
        check("ovf_err",    32'(b_err_ovf), 1);
        check("ovf_ready",  32'(b_in_ready), 0);
        check("ovf_cpurst", 32'(b_cpu_reset), 1);
        check("ovf_busy",   32'(b_busy), 0);
        check("ovf_cnt",    32'(b_loaded_cnt), 15);
        tick();
        check("ovf_nowr",   32'(b_rom_we), 0);
        check("ovf_sticky", 32'(b_err_ovf), 1);
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ovf_clr",    32'(b_err_ovf), 0);
        check("ovf_reload", 32'(b_in_ready), 1);
        check("ovf_cnt0",   32'(b_loaded_cnt), 0);
        in_valid = 1'b1; in_data = 9'h123; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("ovf_re_we",   32'(b_rom_we), 1);
        check("ovf_re_addr", 32'(b_rom_addr), 0);
        check("ovf_re_wdat", 32'(b_rom_wdat), 32'h123);

        // D=4: maximum-length program with in_last on word 15
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_data = 9'(9'h100 | i); in_last = (i == 14);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("max_addr", 32'(b_rom_addr), 14);
        check("max_wdat", 32'(b_rom_wdat), 32'h10E);
        check("max_err",  32'(b_err_ovf), 0);
        check("max_rel",  32'(b_busy), 1);
        tick();
        check("max_run",  32'(b_cpu_reset), 0);
        check("max_cnt",  32'(b_loaded_cnt), 15);

        // Asynchronous reset after two words
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 9'h0AA;
        tick();
        in_data = 9'h0BB;
        tick();
        check("ar_pre_addr", 32'(a_rom_addr), 1);
        in_valid = 1'b0;
        reset = 1'b0;
        #2;
        check("ar_we",     32'(a_rom_we), 0);
        check("ar_addr",   32'(a_rom_addr), 0);
        check("ar_wdat",   32'(a_rom_wdat), 0);
        check("ar_cpurst", 32'(a_cpu_reset), 1);
        check("ar_busy",   32'(a_busy), 0);
        check("ar_ready",  32'(a_in_ready), 0);
        check("ar_cnt",    32'(a_loaded_cnt), 0);
        tick();
        reset = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 9'h0CC; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("ar_re_we",   32'(a_rom_we), 1);
        check("ar_re_addr", 32'(a_rom_addr), 0);
        check("ar_re_wdat", 32'(a_rom_wdat), 32'h0CC);
        check("ar_re_cnt",  32'(a_loaded_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
